// File: rtl/mc_result_tx.sv
// -----------------------------------------------------------------------------
// mc_result_tx
//
// Sends one Monte Carlo points count over a UART line. The count is written as
// ASCII hex, most significant nibble first, and followed by CR and LF.
//
// A result is accepted on a valid/ready handshake. The block has no buffer:
// while a frame is being sent, result_ready stays low and new results are
// ignored. The accepted value is latched, so later changes on the result input
// cannot corrupt the frame that is on the line.
//
// Each character goes out as 8N1:
//   - one start bit (0)
//   - eight data bits, LSB first
//   - one stop bit (1)
// Every bit lasts CLKS_PER_BIT clocks. Characters follow each other with no
// idle time between them.
//
// Frame length: NCH = ceil(WIDTH/4) + 2 characters, which is NCH*10*CLKS_PER_BIT
// clocks. If the result is accepted at cycle k:
//   - tx goes low at cycle k+1;
//   - the last stop bit ends at cycle k+NCH*10*CLKS_PER_BIT;
//   - result_ready is high again one cycle later.
//
// Parameters
//   WIDTH         result width in bits (1..32)
//   CLKS_PER_BIT  UART bit period in clk cycles (>= 2)
//
// Ports
//   clk           clock; all logic runs on the rising edge
//   rst           synchronous, active-high reset; aborts any frame in flight
//   result_valid  result holds a finished count
//   result        points count from the estimator
//   result_ready  block can accept a result this cycle (IDLE only)
//   tx            UART serial line, idle high, driven from a register
//   busy          a frame is being transmitted (= !result_ready)
// -----------------------------------------------------------------------------
module mc_result_tx #(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             result_valid,
    input  logic [WIDTH-1:0] result,
    output logic             result_ready,
    output logic             tx,
    output logic             busy
);

    // -------------------------------------------------------------------------
    // Derived sizes
    // -------------------------------------------------------------------------
    localparam int NDIG  = (WIDTH + 3) / 4;       // hex digits per frame
    localparam int NCH   = NDIG + 2;              // digits + CR + LF
    localparam int PAD_W = 4 * NDIG;              // result widened to whole nibbles
    localparam int CNT_W = $clog2(CLKS_PER_BIT);  // bit-period counter width
    localparam int IDX_W = $clog2(NCH);           // character index width

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NCH - 1);
    localparam logic [IDX_W-1:0] IDX_CR    = IDX_W'(NDIG);
    localparam logic [2:0]       BIT_LAST  = 3'd7;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // -------------------------------------------------------------------------
    // Transmit sequencer states
    //
    // LOAD_CHAR holds the line low. It is the first clock of the start bit, so
    // START only waits out the remaining CLKS_PER_BIT-1 clocks. Because of this,
    // fetching a character adds no time to the frame, and characters follow
    // each other without gaps.
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        IDLE,
        LOAD_CHAR,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state_q,    state_d;
    logic [CNT_W-1:0] bit_cnt_q,  bit_cnt_d;   // clocks within the current bit
    logic [2:0]       bit_idx_q,  bit_idx_d;   // data bit being sent
    logic [IDX_W-1:0] char_idx_q, char_idx_d;  // character within the frame
    logic [7:0]       shift_q,    shift_d;     // character being serialised
    logic [WIDTH-1:0] result_q,   result_d;    // count latched at accept
    logic             tx_q,       tx_d;

    // -------------------------------------------------------------------------
    // Character generator
    //
    // The digit selected by char_idx_q is taken from the latched count. The
    // count is zero-extended to whole nibbles, so the top digit is zero-padded
    // when WIDTH is not a multiple of 4.
    // -------------------------------------------------------------------------
    logic [PAD_W-1:0] result_pad;
    logic [3:0]       nibble;
    logic [7:0]       cur_char;

    assign result_pad = PAD_W'(result_q);

    // 0-9 -> '0'-'9', 10-15 -> 'A'-'F' (0x37 + 10 = 0x41)
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        logic [7:0] code;
        if (nib < 4'd10) begin
            code = 8'h30 + {4'h0, nib};
        end else begin
            code = 8'h37 + {4'h0, nib};
        end
        return code;
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the block can leave it unassigned and infer a latch.
        nibble   = 4'h0;
        cur_char = ASCII_LF;

        // Character 0 carries the most significant nibble.
        for (int d = 0; d < NDIG; d++) begin
            if (char_idx_q == IDX_W'(d)) begin
                nibble = result_pad[PAD_W-1-4*d -: 4];
            end
        end

        if (char_idx_q < IDX_CR) begin
            cur_char = hex_ascii(nibble);
        end else if (char_idx_q == IDX_CR) begin
            cur_char = ASCII_CR;
        end else begin
            cur_char = ASCII_LF;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        bit_idx_d  = bit_idx_q;
        char_idx_d = char_idx_q;
        shift_d    = shift_q;
        result_d   = result_q;
        tx_d       = tx_q;

        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (result_valid) begin
                    // Accept: latch the count and start the first start bit on
                    // the next clock.
                    result_d   = result;
                    char_idx_d = '0;
                    bit_cnt_d  = '0;
                    tx_d       = 1'b0;
                    state_d    = LOAD_CHAR;
                end
            end

            LOAD_CHAR: begin
                // First clock of the start bit. The line is already low.
                shift_d   = cur_char;
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                state_d   = START;
            end

            START: begin
                if (bit_cnt_q == CNT_LAST) begin
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                    state_d   = DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                if (bit_cnt_q == CNT_LAST) begin
                    bit_cnt_d = '0;
                    if (bit_idx_q == BIT_LAST) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        // Present the next bit while shifting, so tx changes
                        // exactly on the bit boundary.
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end

            STOP: begin
                if (bit_cnt_q == CNT_LAST) begin
                    bit_cnt_d = '0;
                    if (char_idx_q == IDX_LAST) begin
                        state_d = IDLE;
                    end else begin
                        // Go straight into the next start bit.
                        char_idx_d = char_idx_q + IDX_W'(1);
                        tx_d       = 1'b0;
                        state_d    = LOAD_CHAR;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    //
    // Reset wins over a simultaneous result_valid. A frame cut short by reset
    // leaves the line high and is not resumed.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: registers update with non-blocking assignments, so every flop
        // samples the values from before this edge, whatever the statement
        // order.
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            char_idx_q <= '0;
            shift_q    <= '0;
            result_q   <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            char_idx_q <= char_idx_d;
            shift_q    <= shift_d;
            result_q   <= result_d;
            tx_q       <= tx_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign tx           = tx_q;
    assign result_ready = (state_q == IDLE);
    assign busy         = ~result_ready;

endmodule

// File: doc/mc_result_tx.md
MC_RESULT_TX -- requirements
Module: mc_result_tx

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the result width in bits (1..32).
REQ-002 Parameter CLKS_PER_BIT, default 868, SHALL set the UART bit period in clk cycles (>= 2).
REQ-003 clk  input  1  SHALL be the clock; all logic on rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 result_valid  input  1  SHALL flag that result holds a finished Monte Carlo count.
REQ-006 result  input  WIDTH  SHALL carry the points count from the estimator.
REQ-007 result_ready  output  1  SHALL flag that the block can accept a result this cycle.
REQ-008 tx  output  1  SHALL be the UART serial line, idle high.
REQ-009 busy  output  1  SHALL be high while a frame is being transmitted.

Function
REQ-010 Handshake: a result SHALL be accepted on the cycle where result_valid && result_ready; result SHALL be latched that cycle.
REQ-011 result_ready SHALL be high only in IDLE; busy SHALL equal !result_ready outside reset.
REQ-012 No buffering: result_valid while busy SHALL be ignored; later changes to result SHALL NOT alter the frame in flight.
REQ-013 Frame: NDIG = ceil(WIDTH/4) ASCII hex digits, most significant nibble first, then 0x0D, then 0x0A; NCH = NDIG+2 characters.
REQ-014 Top nibble SHALL be zero-padded when WIDTH is not a multiple of 4.
REQ-015 Digit encoding: nibble 0-9 -> 0x30-0x39, A-F -> 0x41-0x46 (uppercase).
REQ-016 Character format SHALL be 8N1: start bit 0, data bits LSB first, one stop bit 1; each bit held exactly CLKS_PER_BIT cycles.
REQ-017 Characters SHALL be sent back-to-back with no extra idle between the stop bit of one and the start bit of the next.
REQ-018 FSM states: IDLE, LOAD_CHAR, START, DATA, STOP; IDLE -> LOAD_CHAR on accept; LOAD_CHAR -> START; START -> DATA after CLKS_PER_BIT; DATA -> STOP after 8 bits; STOP -> LOAD_CHAR if characters remain, else IDLE.
REQ-019 LOAD_CHAR SHALL consume no bit time: timing in REQ-020/021 is exact.
REQ-020 Latency: with acceptance at cycle k, tx SHALL go low at cycle k+1 (registered output).
REQ-021 The last stop bit SHALL end at cycle k+NCH*10*CLKS_PER_BIT; result_ready SHALL be high at cycle k+1+NCH*10*CLKS_PER_BIT.
REQ-022 With result_valid held high, the next frame SHALL be accepted the first cycle ready is high, giving exactly one extra idle-high cycle between frames.
REQ-023 Bit-period counter SHALL count 0..CLKS_PER_BIT-1 and wrap; width SHALL be $clog2(CLKS_PER_BIT).
REQ-024 Character index SHALL count 0..NCH-1 and SHALL NOT wrap within a frame.
REQ-025 tx SHALL be driven from a register; no combinational path from inputs to tx.

Reset
REQ-026 While rst is high at a rising edge: state IDLE, tx=1, result_ready=1 on the next cycle, busy=0, counters and latched result cleared.
REQ-027 rst mid-frame SHALL abort the frame: tx=1 the cycle after rst is sampled, no further start bits, no partial character resumed.
REQ-028 rst SHALL take priority over a simultaneous result_valid; nothing is accepted that cycle.

Verification (CLKS_PER_BIT=4 in simulation)
REQ-029 rst high 3 cycles -> tx=1, result_ready=1, busy=0; no tx low for 200 cycles with result_valid=0.
REQ-030 WIDTH=4, result=0xA pulsed 1 cycle -> decoded bytes 0x41,0x0D,0x0A; tx low at k+1; result_ready high at k+121.
REQ-031 WIDTH=6, result=0x2F -> bytes 0x32,0x46,0x0D,0x0A; busy high for exactly 160 cycles.
REQ-032 Accept 0x3; pulse result_valid with 0x7 mid-frame -> result_ready=0, frame still decodes 0x33,0x0D,0x0A, 0x7 never sent.
REQ-033 rst at cycle k+15 of a frame -> tx=1 from k+16, result_ready=1, line stays high until a new accept.
REQ-034 result_valid held high, result=0x5 -> two consecutive 0x35,0x0D,0x0A frames with exactly 1 idle-high cycle between them.
